// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and refill-side buses of the direct-mapped instruction cache.
// The slave modport is the cache's view; master is the core/memory side.
interface icache_direct_mapped_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
);
    logic                  fetch_valid;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ready;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_done;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  fetch_valid, fetch_addr, mem_ack, mem_rdata,
        output fetch_ready, fetch_data, fetch_done, mem_req, mem_addr
    );

    modport master (
        output fetch_valid, fetch_addr, mem_ack, mem_rdata,
        input  fetch_ready, fetch_data, fetch_done, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache with word-by-word line refill over req/ack.
// Defining ICACHE_STATS_EN adds free-running hit_count / miss_count outputs.
module icache_direct_mapped #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_COUNT     = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clock,
    input  logic                  not_reset,
    input  logic                  not_enable,
    input  logic                  flush,
    icache_direct_mapped_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINE_COUNT);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int DEPTH = LINE_COUNT * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFILL  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [TAG_W-1:0]      r_tag  [LINE_COUNT];
    logic [LINE_COUNT-1:0] r_valid;

    logic [DATA_WIDTH-1:0] r_fetch_data;
    logic                  r_fetch_done;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [OFF_W-1:0]      r_beat;
    logic                  r_pflush;
    logic [TAG_W-1:0]      r_tag_l;
    logic [IDX_W-1:0]      r_idx_l;
    logic [OFF_W-1:0]      r_off_l;

    logic [OFF_W-1:0]      w_off;
    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_hit;
    logic                  w_beat;
    logic                  w_last;

    assign w_off    = bus.fetch_addr[OFF_W-1:0];
    assign w_idx    = bus.fetch_addr[OFF_W +: IDX_W];
    assign w_tag    = bus.fetch_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_ready  = (r_state == ST_IDLE) && !not_enable && !flush && !r_pflush;
    assign w_accept = bus.fetch_valid && w_ready;
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // r_mem_req is only ever high in REFILL, so this marks a completed beat.
    assign w_beat   = r_mem_req && bus.mem_ack;
    assign w_last   = (r_beat == OFF_W'(WORDS_PER_LINE - 1));

    assign bus.fetch_ready = w_ready;
    assign bus.fetch_data  = r_fetch_data;
    assign bus.fetch_done  = r_fetch_done;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;

    // State register.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_hit) begin
                    w_next = ST_REFILL;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REFILL: begin
                if (w_beat && w_last) begin
                    w_next = ST_RESPOND;
                end else begin
                    w_next = ST_REFILL;
                end
            end
            ST_RESPOND: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Control, valid bits and registered outputs.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            r_valid      <= '0;
            r_fetch_data <= '0;
            r_fetch_done <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_beat       <= '0;
            r_pflush     <= 1'b0;
            r_tag_l      <= '0;
            r_idx_l      <= '0;
            r_off_l      <= '0;
        end else begin
            r_fetch_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (not_enable) begin
                        r_fetch_data <= '0;
                    end
                    // A flush deferred from a refill lands here, taking the fresh line too.
                    if (flush || r_pflush) begin
                        r_valid  <= '0;
                        r_pflush <= 1'b0;
                    end
                    if (w_accept) begin
                        r_tag_l <= w_tag;
                        r_idx_l <= w_idx;
                        r_off_l <= w_off;
                        if (w_hit) begin
                            r_fetch_data <= r_data[{w_idx, w_off}];
                            r_fetch_done <= 1'b1;
                        end else begin
                            r_valid[w_idx] <= 1'b0;
                            r_mem_req      <= 1'b1;
                            r_mem_addr     <= {w_tag, w_idx, {OFF_W{1'b0}}};
                            r_beat         <= '0;
                        end
                    end
                end
                ST_REFILL: begin
                    if (flush) begin
                        r_pflush <= 1'b1;
                    end
                    if (w_beat) begin
                        r_beat     <= r_beat + OFF_W'(1);
                        r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
                        if (w_last) begin
                            r_mem_req        <= 1'b0;
                            r_valid[r_idx_l] <= 1'b1;
                        end
                    end
                end
                ST_RESPOND: begin
                    if (flush) begin
                        r_pflush <= 1'b1;
                    end
                    r_fetch_data <= r_data[{r_idx_l, r_off_l}];
                    r_fetch_done <= 1'b1;
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Line storage; contents are qualified by r_valid so they need no reset.
    always_ff @(posedge clock) begin
        if (w_beat) begin
            r_data[{r_idx_l, r_beat}] <= bus.mem_rdata;
            if (w_last) begin
                r_tag[r_idx_l] <= r_tag_l;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Accepted-fetch statistics; cleared only by not_reset.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else if (w_accept) begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end else begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: directed scenarios plus random traffic,
// checked every cycle against a line-level behavioural cache model.
module tb_icache_direct_mapped;
    localparam int L  = 4;
    localparam int W  = 4;
    localparam int AW = 12;
    localparam int DW = 16;

    logic clock;
    logic not_reset;
    logic not_enable;
    logic flush;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_direct_mapped_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    icache_direct_mapped #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_COUNT(L), .WORDS_PER_LINE(W)
    ) dut (
        .clock(clock),
        .not_reset(not_reset),
        .not_enable(not_enable),
        .flush(flush),
        .bus(bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 16'h1110 + {4'b0000, a};
    endfunction

    assign bus.mem_rdata = mem_word(bus.mem_addr);

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;
    int ack_mode = 0;
    int stall_cnt = 0;
    logic [AW-1:0] beat_q[$];
    logic [DW-1:0] done_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Behavioural model: cache contents per line plus one outstanding miss.
    bit            m_valid [L];
    int            m_tag   [L];
    bit            m_busy    = 1'b0;
    bit            m_resp    = 1'b0;
    bit            m_pflush  = 1'b0;
    int            m_miss_addr = 0;
    int            m_beats   = 0;
    int            m_hits    = 0;
    int            m_misses  = 0;
    logic [DW-1:0] e_data  = '0;
    bit            e_done  = 1'b0;
    bit            e_req   = 1'b0;
    logic [AW-1:0] e_maddr = '0;

    function automatic bit model_ready();
        return !m_busy && !m_resp && !not_enable && !flush && !m_pflush;
    endfunction

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_busy = 1'b0; m_resp = 1'b0; m_pflush = 1'b0; m_beats = 0;
        m_hits = 0; m_misses = 0;
        e_data = '0; e_done = 1'b0; e_req = 1'b0; e_maddr = '0;
    endtask

    task automatic model_step();
        int a, idx, tg;
        bit rdy;
        rdy = model_ready();
        e_done = 1'b0;
        if (m_resp) begin
            e_data = mem_word(AW'(m_miss_addr));
            e_done = 1'b1;
            m_resp = 1'b0;
            if (flush) m_pflush = 1'b1;
        end else if (m_busy) begin
            if (flush) m_pflush = 1'b1;
            if (bus.mem_ack) begin
                m_beats++;
                if (m_beats == W) begin
                    idx = (m_miss_addr / W) % L;
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = m_miss_addr / (W * L);
                    m_busy = 1'b0;
                    e_req  = 1'b0;
                    m_resp = 1'b1;
                end else begin
                    e_maddr = e_maddr + AW'(1);
                end
            end
        end else begin
            if (not_enable) e_data = '0;
            if (flush || m_pflush) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
                m_pflush = 1'b0;
            end
            if (rdy && bus.fetch_valid) begin
                a   = int'(bus.fetch_addr);
                idx = (a / W) % L;
                tg  = a / (W * L);
                if (m_valid[idx] && m_tag[idx] == tg) begin
                    e_data = mem_word(bus.fetch_addr);
                    e_done = 1'b1;
                    m_hits++;
                end else begin
                    m_valid[idx] = 1'b0;
                    m_busy      = 1'b1;
                    m_beats     = 0;
                    m_miss_addr = a;
                    e_req       = 1'b1;
                    e_maddr     = AW'(a - (a % W));
                    m_misses++;
                end
            end
        end
    endtask

    always @(posedge clock or negedge not_reset) begin
        if (!not_reset) model_reset();
        else model_step();
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (not_reset && bus.mem_req && bus.mem_ack) beat_q.push_back(bus.mem_addr);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        chk("fetch_ready", 32'(bus.fetch_ready), 32'(model_ready()));
        chk("fetch_done",  32'(bus.fetch_done),  32'(e_done));
        chk("fetch_data",  32'(bus.fetch_data),  32'(e_data));
        chk("mem_req",     32'(bus.mem_req),     32'(e_req));
        if (e_req) chk("mem_addr", 32'(bus.mem_addr), 32'(e_maddr));
`ifdef ICACHE_STATS_EN
        chk("hit_count",  hit_count,  32'(m_hits));
        chk("miss_count", miss_count, 32'(m_misses));
`endif
        if (bus.fetch_done) done_q.push_back(bus.fetch_data);
    end

    // Memory responder: immediate, 3-cycle stall per beat, or random ack.
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(negedge clock); #1;
            case (ack_mode)
                0: bus.mem_ack = 1'b1;
                1: begin
                    if (bus.mem_req) begin
                        if (stall_cnt == 3) begin
                            bus.mem_ack = 1'b1;
                            stall_cnt = 0;
                        end else begin
                            bus.mem_ack = 1'b0;
                            stall_cnt++;
                        end
                    end else begin
                        bus.mem_ack = 1'b0;
                        stall_cnt = 0;
                    end
                end
                default: bus.mem_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Issue one fetch and wait for its response; optionally pulse flush or
    // raise not_enable a given number of cycles after acceptance.
    task automatic do_fetch(input logic [AW-1:0] a, input int flush_at, input int nen_at,
                            output int lat, output logic [DW-1:0] d);
        int acc, g;
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = a;
        #1;
        g = 0;
        while (!bus.fetch_ready && g < 50) begin
            @(negedge clock); #1; g++;
        end
        chk("accept_ready", 32'(bus.fetch_ready), 32'd1);
        acc = cyc;
        @(negedge clock); #1;
        bus.fetch_valid = 1'b0;
        g = 0;
        while (!bus.fetch_done && g < 200) begin
            flush = (g == flush_at);
            if (nen_at >= 0 && g >= nen_at) not_enable = 1'b1;
            @(negedge clock); #1; g++;
        end
        flush = 1'b0;
        chk("done_seen", 32'(bus.fetch_done), 32'd1);
        lat = cyc - acc;
        d   = bus.fetch_data;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [DW-1:0] d;
        not_reset = 1'b0; not_enable = 1'b0; flush = 1'b0;
        bus.fetch_valid = 1'b0; bus.fetch_addr = '0;
        repeat (2) @(negedge clock);
        chk("rst_fetch_data", 32'(bus.fetch_data), 32'd0);
        chk("rst_mem_req",    32'(bus.mem_req),    32'd0);
        chk("rst_fetch_done", 32'(bus.fetch_done), 32'd0);
        #1 not_reset = 1'b1;
        @(negedge clock); #1;

        // Cold miss on 0x5.
        beat_q.delete();
        do_fetch(12'h005, -1, -1, lat, d);
        chk("cold_latency", 32'(lat), 32'd6);
        chk("cold_data",    32'(d),   32'h1115);
        chk("cold_beats",   32'(beat_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("cold_beat_addr", 32'(beat_q[i]), 32'(4 + i));

        // Back-to-back hits in the freshly filled line.
        done_q.delete(); beat_q.delete();
        bus.fetch_valid = 1'b1; bus.fetch_addr = 12'h004;
        @(negedge clock); #1; bus.fetch_addr = 12'h006;
        @(negedge clock); #1; bus.fetch_addr = 12'h007;
        @(negedge clock); #1; bus.fetch_valid = 1'b0;
        @(negedge clock); #1;
        chk("hit_stream_count", 32'(done_q.size()), 32'd3);
        chk("hit_stream_d0", 32'(done_q[0]), 32'h1114);
        chk("hit_stream_d1", 32'(done_q[1]), 32'h1116);
        chk("hit_stream_d2", 32'(done_q[2]), 32'h1117);
        chk("hit_stream_no_beats", 32'(beat_q.size()), 32'd0);

        // Conflict miss on index 1, then the evicted line misses again.
        beat_q.delete();
        do_fetch(12'h015, -1, -1, lat, d);
        chk("conflict_data", 32'(d), 32'h1125);
        chk("conflict_first_beat", 32'(beat_q[0]), 32'h014);
        do_fetch(12'h005, -1, -1, lat, d);
        chk("evicted_latency", 32'(lat), 32'd6);

        // Ack stalled three cycles per beat.
        ack_mode = 1; beat_q.delete();
        do_fetch(12'h026, -1, -1, lat, d);
        chk("stall_latency", 32'(lat), 32'd18);
        chk("stall_data",    32'(d),   32'h1136);
        chk("stall_beats",   32'(beat_q.size()), 32'd4);
        ack_mode = 0;

        // Flush during refill of 0x8.
        do_fetch(12'h008, 1, -1, lat, d);
        chk("flush_data", 32'(d), 32'h1118);
        chk("flush_ready_low", 32'(bus.fetch_ready), 32'd0);
        @(negedge clock); #1;
        chk("flush_ready_back", 32'(bus.fetch_ready), 32'd1);
        do_fetch(12'h008, -1, -1, lat, d);
        chk("flush_refetch_latency", 32'(lat), 32'd6);

        // not_enable in IDLE blocks acceptance and zeroes fetch_data.
        not_enable = 1'b1; bus.fetch_valid = 1'b1; bus.fetch_addr = 12'h008;
        #1;
        chk("nen_ready", 32'(bus.fetch_ready), 32'd0);
        @(negedge clock); #1;
        chk("nen_data_zero", 32'(bus.fetch_data), 32'd0);
        bus.fetch_valid = 1'b0; not_enable = 1'b0;
        @(negedge clock); #1;

        // not_enable raised during a refill: response still delivered.
        do_fetch(12'h02C, -1, 0, lat, d);
        chk("nen_refill_latency", 32'(lat), 32'd6);
        chk("nen_refill_data",    32'(d),   32'h113C);
        @(negedge clock); #1;
        not_enable = 1'b0;

        // Reset pulsed mid-refill.
        bus.fetch_valid = 1'b1; bus.fetch_addr = 12'h030;
        @(negedge clock); #1; bus.fetch_valid = 1'b0;
        @(negedge clock); #1;
        chk("pre_reset_req", 32'(bus.mem_req), 32'd1);
        not_reset = 1'b0;
        #1;
        chk("reset_drops_req", 32'(bus.mem_req), 32'd0);
        @(negedge clock); #1; not_reset = 1'b1;
        @(negedge clock); #1;
        do_fetch(12'h030, -1, -1, lat, d);
        chk("post_reset_latency", 32'(lat), 32'd6);
        chk("post_reset_data",    32'(d),   32'h1140);

        // Random traffic with random ack timing.
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock); #1;
            bus.fetch_valid = ($urandom_range(0, 9) < 7);
            bus.fetch_addr  = AW'($urandom_range(0, 63));
            flush           = ($urandom_range(0, 99) < 3);
            not_enable      = ($urandom_range(0, 99) < 5);
        end
        @(negedge clock); #1;
        bus.fetch_valid = 1'b0; flush = 1'b0; not_enable = 1'b0;
        repeat (40) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
